// File: rtl/dice_controller.sv
// Craps game sequencer for dice_datapath: conditions the roll button, times each
// roll, evaluates the datapath flags and keeps per-game and cumulative statistics.
module dice_controller #(
  parameter int unsigned HOLD_MIN = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Rb,
  input  logic             new_game,
  input  logic             D7,
  input  logic             D711,
  input  logic             D2312,
  input  logic             Eq,
  output logic             Roll,
  output logic             Sp,
  output logic             Win,
  output logic             Lose,
  output logic [CNT_W-1:0] roll_count,
  output logic [CNT_W-1:0] win_count,
  output logic [CNT_W-1:0] loss_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ROLL1  = 4'd1,
    CHECK1 = 4'd2,
    SAVE   = 4'd3,
    PWAIT  = 4'd4,
    ROLLN  = 4'd5,
    CHECKN = 4'd6,
    WIN    = 4'd7,
    LOSE   = 4'd8
  } state_t;

  localparam logic [3:0] HOLD_MAX  = 4'(HOLD_MIN);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MIN - 1);

  state_t     cur, nxt;
  logic       rb_m, rb_s, rb_d, rb_rise;
  logic [3:0] hold_cnt;
  logic       hold_done;
  logic       in_roll;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rb_m <= 1'b0;
      rb_s <= 1'b0;
      rb_d <= 1'b0;
    end else begin
      rb_m <= Rb;
      rb_s <= rb_m;
      rb_d <= rb_s;
    end
  end

  assign rb_rise = rb_s & ~rb_d;
  assign in_roll = (cur == ROLL1) || (cur == ROLLN);

  // hold_cnt counts Roll cycles already completed, so the current cycle is the
  // HOLD_MIN-th one once it reaches HOLD_MIN-1; this yields exactly HOLD_MIN cycles.
  assign hold_done = (hold_cnt >= HOLD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (!in_roll) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= IDLE;
    else      cur <= nxt;
  end

  always_comb begin
    nxt  = cur;
    Roll = 1'b0;
    Sp   = 1'b0;
    Win  = 1'b0;
    Lose = 1'b0;
    case (cur)
      IDLE:   if (rb_rise) nxt = ROLL1;
      ROLL1: begin
        Roll = 1'b1;
        if (!rb_s && hold_done) nxt = CHECK1;
      end
      CHECK1: begin
        if (D711)       nxt = WIN;
        else if (D2312) nxt = LOSE;
        else            nxt = SAVE;
      end
      SAVE: begin
        Sp  = 1'b1;
        nxt = PWAIT;
      end
      PWAIT:  if (rb_rise) nxt = ROLLN;
      ROLLN: begin
        Roll = 1'b1;
        if (!rb_s && hold_done) nxt = CHECKN;
      end
      CHECKN: begin
        if (Eq)      nxt = WIN;
        else if (D7) nxt = LOSE;
        else         nxt = PWAIT;
      end
      WIN:    Win  = 1'b1;
      LOSE:   Lose = 1'b1;
      default: nxt = IDLE;
    endcase
    if (new_game) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      roll_count <= '0;
      win_count  <= '0;
      loss_count <= '0;
    end else begin
      if (nxt == IDLE) begin
        roll_count <= '0;
      end else if (((cur == ROLL1 && nxt == CHECK1) || (cur == ROLLN && nxt == CHECKN))
                   && roll_count != '1) begin
        roll_count <= roll_count + 1'b1;
      end
      if ((cur == CHECK1 || cur == CHECKN) && nxt == WIN && win_count != '1)
        win_count <= win_count + 1'b1;
      if ((cur == CHECK1 || cur == CHECKN) && nxt == LOSE && loss_count != '1)
        loss_count <= loss_count + 1'b1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_dice_controller.sv
// Bench for dice_controller: plays craps at the game level (dice sums, point)
// and compares roll lengths, point strobes, outcomes and counters.
module tb_dice_controller;
  localparam int HOLD_MIN = 4;
  localparam int CNT_W    = 2;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic Rb = 1'b0, new_game = 1'b0;
  logic D7 = 1'b0, D711 = 1'b0, D2312 = 1'b0, Eq = 1'b0;
  logic Roll, Sp, Win, Lose;
  logic [CNT_W-1:0] roll_count, win_count, loss_count;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // game-level reference model
  int m_phase  = 0;   // 0 come-out, 1 point established, 2 game over
  int m_point  = 0;
  int m_rolls  = 0;
  int m_wins   = 0;
  int m_losses = 0;
  bit m_won    = 1'b0;

  dice_controller #(.HOLD_MIN(HOLD_MIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Rb(Rb), .new_game(new_game),
    .D7(D7), .D711(D711), .D2312(D2312), .Eq(Eq),
    .Roll(Roll), .Sp(Sp), .Win(Win), .Lose(Lose),
    .roll_count(roll_count), .win_count(win_count), .loss_count(loss_count),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  function automatic int sat_inc(input int v);
    return (v < MAXC) ? v + 1 : MAXC;
  endfunction

  function automatic int exp_state();
    if (m_phase == 1) return 4;
    if (m_phase == 2) return m_won ? 7 : 8;
    return 0;
  endfunction

  function automatic int exp_roll_len(input int press);
    return (press > HOLD_MIN) ? press : HOLD_MIN;
  endfunction

  task automatic model_roll(input int sum, output int exp_sp);
    exp_sp  = 0;
    m_rolls = sat_inc(m_rolls);
    if (m_phase == 0) begin
      if (sum == 7 || sum == 11) begin
        m_phase = 2; m_won = 1'b1; m_wins = sat_inc(m_wins);
      end else if (sum == 2 || sum == 3 || sum == 12) begin
        m_phase = 2; m_won = 1'b0; m_losses = sat_inc(m_losses);
      end else begin
        m_point = sum; m_phase = 1; exp_sp = 1;
      end
    end else if (m_phase == 1) begin
      if (sum == m_point) begin
        m_phase = 2; m_won = 1'b1; m_wins = sat_inc(m_wins);
      end else if (sum == 7) begin
        m_phase = 2; m_won = 1'b0; m_losses = sat_inc(m_losses);
      end
    end
  endtask

  // Presents the flags for a dice sum, holds Rb for `press` cycles and counts
  // Roll/Sp cycles over a window long enough for the roll to finish.
  task automatic press_roll(input int press, input int sum, output int rc, output int sc);
    rc    = 0;
    sc    = 0;
    D7    = (sum == 7);
    D711  = (sum == 7 || sum == 11);
    D2312 = (sum == 2 || sum == 3 || sum == 12);
    Eq    = (m_phase == 1) ? (sum == m_point) : ($urandom_range(0, 1) == 1);
    Rb    = 1'b1;
    for (int i = 0; i < press + HOLD_MIN + 8; i++) begin
      @(negedge clk);
      rc += int'(Roll);
      sc += int'(Sp);
      if (i == press - 1) Rb = 1'b0;
    end
  endtask

  task automatic start_new_game();
    @(negedge clk) new_game = 1'b1;
    @(negedge clk) new_game = 1'b0;
    m_phase = 0;
    m_rolls = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if ({Roll, Sp, Win, Lose} !== 4'b0) begin n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {Roll, Sp, Win, Lose}); end
    n_checks++; if ({roll_count, win_count, loss_count} !== '0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", roll_count, win_count, loss_count); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    Rb = 1'b1;
    for (int i = 0; i < 10 && Roll !== 1'b1; i++) @(negedge clk);
    n_checks++; if (Roll !== 1'b1) begin n_fail++; $display("FAIL reset_reach_roll: got Roll=%b expected 1", Roll); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (Roll !== 1'b0 || state !== 4'd0) begin n_fail++; $display("FAIL reset_midroll: got Roll=%b state=%0d expected Roll=0 state=0", Roll, state); end
    Rb = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (state !== 4'd0 || roll_count !== '0) begin n_fail++; $display("FAIL reset_release: got state=%0d rolls=%0d expected 0/0", state, roll_count); end
    m_phase = 0; m_rolls = 0; m_wins = 0; m_losses = 0;
  endtask

  task automatic test_natural_win();
    int rc, sc, es;
    press_roll(10, 7, rc, sc);
    model_roll(7, es);
    n_checks++; if (rc != 10) begin n_fail++; $display("FAIL natural_roll_len: got %0d expected 10", rc); end
    n_checks++; if (sc != 0) begin n_fail++; $display("FAIL natural_sp: got %0d expected 0", sc); end
    n_checks++; if (state !== 4'd7 || Win !== 1'b1 || Lose !== 1'b0) begin n_fail++; $display("FAIL natural_win: got state=%0d Win=%b Lose=%b expected 7/1/0", state, Win, Lose); end
    n_checks++; if (win_count !== m_wins || roll_count !== 1) begin n_fail++; $display("FAIL natural_counts: got wins=%0d rolls=%0d expected %0d/1", win_count, roll_count, m_wins); end
    Rb = 1'b1;
    rc = 0;
    repeat (8) begin @(negedge clk); rc += int'(Roll); end
    n_checks++; if (rc != 0 || state !== 4'd7) begin n_fail++; $display("FAIL hold_in_win: got roll=%0d state=%0d expected 0/7", rc, state); end
    Rb = 1'b0;
    repeat (3) @(negedge clk);
    start_new_game();
    n_checks++; if (state !== 4'd0 || roll_count !== '0 || win_count !== m_wins) begin n_fail++; $display("FAIL new_game_idle: got state=%0d rolls=%0d wins=%0d expected 0/0/%0d", state, roll_count, win_count, m_wins); end
  endtask

  task automatic test_point_win();
    int rc, sc, es;
    press_roll(5, 5, rc, sc);
    model_roll(5, es);
    n_checks++; if (sc != 1 || rc != 5) begin n_fail++; $display("FAIL point_set: got sp=%0d roll=%0d expected 1/5", sc, rc); end
    n_checks++; if (state !== 4'd4) begin n_fail++; $display("FAIL point_pwait: got %0d expected 4", state); end
    press_roll(3, 5, rc, sc);
    model_roll(5, es);
    n_checks++; if (rc != 4 || sc != 0) begin n_fail++; $display("FAIL point_roll2: got roll=%0d sp=%0d expected 4/0", rc, sc); end
    n_checks++; if (state !== 4'd7 || Win !== 1'b1 || roll_count !== 2) begin n_fail++; $display("FAIL point_win: got state=%0d Win=%b rolls=%0d expected 7/1/2", state, Win, roll_count); end
    start_new_game();
  endtask

  task automatic test_seven_out();
    int rc, sc, es;
    press_roll(6, 8, rc, sc);
    model_roll(8, es);
    press_roll(4, 6, rc, sc);
    model_roll(6, es);
    n_checks++; if (state !== 4'd4 || sc != 0) begin n_fail++; $display("FAIL sevenout_miss: got state=%0d sp=%0d expected 4/0", state, sc); end
    press_roll(4, 7, rc, sc);
    model_roll(7, es);
    n_checks++; if (state !== 4'd8 || Lose !== 1'b1 || Win !== 1'b0) begin n_fail++; $display("FAIL sevenout_lose: got state=%0d Lose=%b Win=%b expected 8/1/0", state, Lose, Win); end
    n_checks++; if (loss_count !== m_losses || roll_count !== 3) begin n_fail++; $display("FAIL sevenout_counts: got losses=%0d rolls=%0d expected %0d/3", loss_count, roll_count, m_losses); end
    start_new_game();
  endtask

  task automatic test_short_press();
    int rc, sc, es;
    press_roll(1, 9, rc, sc);
    model_roll(9, es);
    n_checks++; if (rc != HOLD_MIN || sc != 1) begin n_fail++; $display("FAIL short_press: got roll=%0d sp=%0d expected %0d/1", rc, sc, HOLD_MIN); end
    // glitches confined between sampling edges never reach the synchronizer
    rc = 0;
    repeat (4) begin
      @(negedge clk);
      #1 Rb = 1'b1;
      #2 Rb = 1'b0;
    end
    repeat (6) begin @(negedge clk); rc += int'(Roll); end
    n_checks++; if (rc != 0 || state !== 4'd4) begin n_fail++; $display("FAIL bounce: got roll=%0d state=%0d expected 0/4", rc, state); end
  endtask

  task automatic test_abort();
    int rc;
    @(negedge clk) Rb = 1'b1;
    @(negedge clk);
    @(negedge clk) new_game = 1'b1;
    @(negedge clk) new_game = 1'b0;
    m_phase = 0;
    m_rolls = 0;
    n_checks++; if (state !== 4'd0 || Roll !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got state=%0d Roll=%b expected 0/0", state, Roll); end
    n_checks++; if (win_count !== m_wins || loss_count !== m_losses || roll_count !== '0) begin n_fail++; $display("FAIL abort_counts: got %0d/%0d/%0d expected %0d/%0d/0", win_count, loss_count, roll_count, m_wins, m_losses); end
    rc = 0;
    repeat (5) begin @(negedge clk); rc += int'(Roll); end
    n_checks++; if (rc != 0 || state !== 4'd0) begin n_fail++; $display("FAIL abort_no_fresh_edge: got roll=%0d state=%0d expected 0/0", rc, state); end
    Rb = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random_games();
    int rc, sc, es, press, sum, guard;
    for (int g = 0; g < 30; g++) begin
      guard = 0;
      while (m_phase < 2 && guard < 12) begin
        press = $urandom_range(1, 12);
        sum   = $urandom_range(1, 6) + $urandom_range(1, 6);
        press_roll(press, sum, rc, sc);
        model_roll(sum, es);
        n_checks++; if (rc != exp_roll_len(press)) begin n_fail++; $display("FAIL rand_roll_len: got %0d expected %0d (press %0d)", rc, exp_roll_len(press), press); end
        n_checks++; if (sc != es) begin n_fail++; $display("FAIL rand_sp: got %0d expected %0d (sum %0d)", sc, es, sum); end
        n_checks++; if (state !== exp_state()) begin n_fail++; $display("FAIL rand_state: got %0d expected %0d (sum %0d point %0d)", state, exp_state(), sum, m_point); end
        n_checks++; if (roll_count !== m_rolls || win_count !== m_wins || loss_count !== m_losses) begin n_fail++; $display("FAIL rand_counts: got %0d/%0d/%0d expected %0d/%0d/%0d", roll_count, win_count, loss_count, m_rolls, m_wins, m_losses); end
        guard++;
      end
      start_new_game();
    end
  endtask

  task automatic test_saturation();
    int rc, sc, es;
    repeat (4) begin
      press_roll(2, 11, rc, sc);
      model_roll(11, es);
      start_new_game();
    end
    n_checks++; if (win_count !== 2'd3) begin n_fail++; $display("FAIL win_saturate: got %0d expected 3", win_count); end
    repeat (4) begin
      press_roll(2, 12, rc, sc);
      model_roll(12, es);
      start_new_game();
    end
    n_checks++; if (loss_count !== 2'd3 || win_count !== 2'd3) begin n_fail++; $display("FAIL loss_saturate: got losses=%0d wins=%0d expected 3/3", loss_count, win_count); end
  endtask

  initial begin
    test_reset();
    test_natural_win();
    test_point_win();
    test_seven_out();
    test_short_press();
    test_abort();
    test_random_games();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
